// File: rtl/ahb_mem_pkg.sv
// Shared AHB-Lite encodings and bridge FSM state type for ahb_to_mem_bridge.
package ahb_mem_pkg;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic [2:0] HsizeByte     = 3'd0;
  localparam logic [2:0] HsizeHalfword = 3'd1;
  localparam logic [2:0] HsizeWord     = 3'd2;

  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StResp,
    StErr1,
    StErr2
  } state_e;

endpackage

// File: rtl/ahb_mem_be_gen.sv
// Byte-enable generation and size/alignment legality check for one AHB address phase.
module ahb_mem_be_gen
  import ahb_mem_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] haddr_lo,
  output logic [3:0] be,
  output logic       illegal
);

  always_comb begin
    be      = 4'b0000;
    illegal = 1'b0;
    case (hsize)
      HsizeByte: be = 4'b0001 << haddr_lo;
      HsizeHalfword: begin
        illegal = haddr_lo[0];
        be      = 4'b0011 << {haddr_lo[1], 1'b0};
      end
      HsizeWord: begin
        illegal = |haddr_lo;
        be      = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
    // Illegal transfers never reach memory, so keep their enables quiet.
    if (illegal) be = 4'b0000;
  end

endmodule

// File: rtl/ahb_to_mem_bridge.sv
// AHB-Lite slave to req/gnt/rvalid memory bridge, one outstanding transfer.
// Optional address range check: define AHB_TO_MEM_RANGE_CHECK_EN.
module ahb_to_mem_bridge
  import ahb_mem_pkg::*;
#(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE_BYTES = 65536
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      hsel_i,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
  input  logic                      hwrite_i,
  input  logic [2:0]                hsize_i,
  input  logic [1:0]                htrans_i,
  input  logic [AHB_DATA_WIDTH-1:0] hwdata_i,
  input  logic                      hready_i,
  output logic                      hreadyout_o,
  output logic                      hresp_o,
  output logic [AHB_DATA_WIDTH-1:0] hrdata_o,
  output logic                      req_o,
  output logic                      we_o,
  output logic [3:0]                be_o,
  output logic [AHB_ADDR_WIDTH-1:0] addr_o,
  output logic [AHB_DATA_WIDTH-1:0] wdata_o,
  input  logic                      gnt_i,
  input  logic                      rvalid_i,
  input  logic [AHB_DATA_WIDTH-1:0] rdata_i
);

  if (AHB_DATA_WIDTH != 32 || MEM_SIZE_BYTES == 0) begin : g_bad_cfg
    $error("ahb_to_mem_bridge: data width must be 32 and memory size non-zero");
  end

  state_e                     state_q, state_d;
  logic [AHB_ADDR_WIDTH-1:2]  waddr_q, waddr_d;
  logic                       we_q, we_d;
  logic [3:0]                 be_q, be_d;
  logic [3:0]                 be_new;
  logic                       size_err, range_err, accept, can_take;

  ahb_mem_be_gen u_be_gen (
    .hsize    (hsize_i),
    .haddr_lo (haddr_i[1:0]),
    .be       (be_new),
    .illegal  (size_err)
  );

`ifdef AHB_TO_MEM_RANGE_CHECK_EN
  assign range_err = (haddr_i >= AHB_ADDR_WIDTH'(MEM_SIZE_BYTES));
`else
  assign range_err = 1'b0;
`endif

  assign accept  = hsel_i & hready_i & ((htrans_i == HtransNonseq) | (htrans_i == HtransSeq));
  assign we_o    = we_q;
  assign be_o    = be_q;
  assign addr_o  = {waddr_q, 2'b00};
  // AHB holds hwdata stable through wait states, so no capture is needed.
  assign wdata_o = hwdata_i;

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    we_d        = we_q;
    be_d        = be_q;
    hreadyout_o = 1'b1;
    hresp_o     = HrespOkay;
    hrdata_o    = '0;
    req_o       = 1'b0;
    can_take    = 1'b0;
    unique case (state_q)
      StIdle: can_take = 1'b1;
      StReq: begin
        req_o       = 1'b1;
        hreadyout_o = 1'b0;
        if (gnt_i) state_d = StResp;
      end
      StResp: begin
        hreadyout_o = rvalid_i;
        if (rvalid_i) begin
          state_d  = StIdle;
          can_take = 1'b1;
          if (!we_q) hrdata_o = rdata_i;
        end
      end
      StErr1: begin
        hresp_o     = HrespError;
        hreadyout_o = 1'b0;
        state_d     = StErr2;
      end
      StErr2: begin
        hresp_o  = HrespError;
        can_take = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (can_take && accept) begin
      waddr_d = haddr_i[AHB_ADDR_WIDTH-1:2];
      we_d    = hwrite_i;
      be_d    = range_err ? 4'b0000 : be_new;
      state_d = (size_err || range_err) ? StErr1 : StReq;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      waddr_q <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      be_q    <= be_d;
    end
  end

endmodule

// File: doc/ahb_to_mem_bridge.md
Name: ahb_to_mem_bridge

Overview:
AHB-Lite slave that converts single AHB transfers into the RI5CY-style req/gnt/rvalid memory interface. It sits between the AHB interconnect and an on-chip memory or peripheral that speaks the core's native memory protocol. It handles one outstanding transfer at a time, inserts wait states until the memory responds, and returns AHB ERROR for illegal transfers.

Parameters:
AHB_ADDR_WIDTH, 32, width of haddr_i and addr_o.
AHB_DATA_WIDTH, 32, width of hwdata_i, hrdata_o, wdata_o and rdata_i; only 32 is supported.
MEM_SIZE_BYTES, 65536, size of the downstream memory; used only when the range check is compiled in.

Ports:
clk  in  1  clock
rstn  in  1  synchronous reset, active-low
hsel_i  in  1  slave select
haddr_i  in  AHB_ADDR_WIDTH  address-phase address
hwrite_i  in  1  1 = write
hsize_i  in  3  transfer size (0 = byte, 1 = halfword, 2 = word)
htrans_i  in  2  transfer type
hwdata_i  in  AHB_DATA_WIDTH  data-phase write data
hready_i  in  1  bus-level HREADY
hreadyout_o  out  1  slave ready
hresp_o  out  1  0 = OKAY, 1 = ERROR
hrdata_o  out  AHB_DATA_WIDTH  read data
req_o  out  1  memory request
we_o  out  1  memory write enable
be_o  out  4  byte enables
addr_o  out  AHB_ADDR_WIDTH  word-aligned address
wdata_o  out  AHB_DATA_WIDTH  write data
gnt_i  in  1  request granted
rvalid_i  in  1  response valid
rdata_i  in  AHB_DATA_WIDTH  read data

Behaviour:
- Reset values: hreadyout_o=1, hresp_o=0, req_o=0, we_o=0, be_o=0, addr_o=0, hrdata_o=0. Reset is synchronous; asserting it mid-transfer returns the FSM to IDLE at the next edge, and any later rvalid_i is ignored.
- Address phase is accepted when hsel_i & hready_i & htrans_i[1] (NONSEQ or SEQ). The block registers haddr_i, hwrite_i and hsize_i, plus be and a legality flag from the sub-module.
- IDLE and BUSY transfers, and cycles with hsel_i=0, get a zero-wait OKAY response. No memory request is issued.
- Byte-enable rules:
  - hsize 0: be = 4'b0001 << haddr[1:0].
  - hsize 1: be = 4'b0011 << {haddr[1],1'b0}.
  - hsize 2: be = 4'b1111.
- Illegal transfers are hsize greater than 2, a halfword with haddr[0]=1, or a word with haddr[1:0] not equal to 0.
- addr_o = {haddr_q[AW-1:2], 2'b00}.
- FSM states:
  - IDLE: hreadyout_o=1. On a legal accept go to REQ; on an illegal accept go to ERR1.
  - REQ: req_o=1 and hreadyout_o=0. we_o, be_o and addr_o come from registers; wdata_o = hwdata_i, which AHB keeps stable during wait states. Stay while gnt_i=0. On gnt_i go to RESP; req_o drops in the following cycle.
  - RESP: req_o=0. hreadyout_o = rvalid_i and hrdata_o = rdata_i, combinational while rvalid_i=1, else hrdata_o holds 0. On rvalid_i the transfer completes OKAY. If a new legal accept happens in that same cycle, go to REQ (back-to-back); if illegal, go to ERR1; otherwise go to IDLE.
  - ERR1: hresp_o=1 and hreadyout_o=0. Always go to ERR2.
  - ERR2: hresp_o=1 and hreadyout_o=1. A new transfer may be accepted here, with the same branching as IDLE.
- Minimum latency is one wait state: address phase at cycle A, req and gnt at A+1, rvalid and hreadyout at A+2. Each cycle gnt or rvalid is late adds one wait state.
- Writes complete on rvalid_i, per the memory protocol. rdata is ignored for writes and hrdata_o stays 0.
- rvalid_i seen in IDLE or REQ, and gnt_i seen outside REQ, are ignored.
- Only one outstanding request; req_o is never re-asserted before rvalid_i.

Optional Feature:
AHB_TO_MEM_RANGE_CHECK_EN
- Defined: an accepted legal-size transfer with haddr_i >= MEM_SIZE_BYTES is treated as illegal. It takes the ERR1/ERR2 path and no req_o is issued.
- Undefined: no address check; all aligned transfers go to memory, and MEM_SIZE_BYTES is unused.

Decomposition:
- Package ahb_mem_pkg holds:
  - HTRANS constants IDLE/BUSY/NONSEQ/SEQ.
  - HSIZE constants BYTE/HALFWORD/WORD.
  - HRESP OKAY/ERROR.
  - The state enum typedef (IDLE, REQ, RESP, ERR1, ERR2).
- One combinational sub-module, ahb_mem_be_gen: inputs hsize and haddr[1:0]; outputs be[3:0] and illegal.

Test Plan:
- Word write to 0x10 with 0xDEADBEEF, gnt immediate, rvalid next cycle -> req_o=1, we_o=1, be_o=1111, addr_o=0x10, wdata_o=0xDEADBEEF; hreadyout_o low for exactly 1 cycle; hresp_o=0.
- Byte read at 0x23, gnt delayed 3 cycles, rdata_i=0x11223344 -> be_o=1000, addr_o=0x20; req_o held for 4 cycles; hrdata_o=0x11223344 on the hreadyout_o=1 cycle.
- Back-to-back halfword writes to 0x42 then 0x40 -> second accepted in the first's completion cycle; be_o=1100 then 0011; no idle cycle between requests.
- Word access at 0x06 -> no req_o; hresp_o=1 for 2 cycles with hreadyout_o 0 then 1.
- Reset asserted while in REQ -> next cycle req_o=0 and hreadyout_o=1; a stray rvalid_i is ignored; the next transfer completes normally.
- With AHB_TO_MEM_RANGE_CHECK_EN and MEM_SIZE_BYTES=0x1000, read at 0x1000 -> ERROR response and no req_o; read at 0xFFC -> OKAY.
